// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: fixed-point Mandelbrot iteration engine with start/done handshake
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   begin a new point; sampled only while busy=0
//   c_re/c_im  in   point c, signed Q(WIDTH-FRAC).FRAC, latched on an accepted start
//   busy       out  high while a point is being computed or reported
//   done       out  one-cycle pulse when diverged/iter_count are valid
//   diverged   out  1 = |z|^2 exceeded 4.0, 0 = iteration limit reached
//   iter_count out  number of z updates performed before termination
module mandel_iter_engine #(
    parameter int WIDTH    = 32,
    parameter int FRAC     = 24,
    parameter int MAX_ITER = 256,
    parameter int ITER_W   = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  c_re,
    input  logic [WIDTH-1:0]  c_im,
    output logic              busy,
    output logic              done,
    output logic              diverged,
    output logic [ITER_W-1:0] iter_count
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    // 4.0 in the fixed-point format, widened by one bit to match the magnitude sum
    localparam logic signed [WIDTH:0] FOUR = {{(WIDTH-FRAC-2){1'b0}}, 3'b100, {FRAC{1'b0}}};

    state_t                   state_q, state_d;
    logic signed [WIDTH-1:0]  c_re_q, c_re_d, c_im_q, c_im_d;
    logic signed [WIDTH-1:0]  z_re_q, z_re_d, z_im_q, z_im_d;
    logic        [ITER_W-1:0] n_q, n_d, cnt_q, cnt_d;
    logic                     div_q, div_d;
    logic signed [WIDTH-1:0]  zr2, zi2, zri;
    logic signed [WIDTH:0]    mag;

    // Full-width signed product, rescaled by FRAC and truncated back to WIDTH bits
    function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = a * b;
        return WIDTH'(p >>> FRAC);
    endfunction

    assign zr2 = fx_mul(z_re_q, z_re_q);
    assign zi2 = fx_mul(z_im_q, z_im_q);
    assign zri = fx_mul(z_re_q, z_im_q);
    // One extra bit so the sum of two squares near the top of the range cannot wrap
    assign mag = {zr2[WIDTH-1], zr2} + {zi2[WIDTH-1], zi2};

    always_comb begin
        state_d = state_q;
        c_re_d  = c_re_q;
        c_im_d  = c_im_q;
        z_re_d  = z_re_q;
        z_im_d  = z_im_q;
        n_d     = n_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = ITER;
                c_re_d  = c_re;
                c_im_d  = c_im;
                z_re_d  = '0;
                z_im_d  = '0;
                n_d     = '0;
            end
        end else if (state_q == ITER) begin
            // Escape test has priority, so an escape at n == MAX_ITER still reports diverged
            if (mag > FOUR) begin
                state_d = DONE;
                div_d   = 1'b1;
                cnt_d   = n_q;
            end else if (n_q == ITER_W'(MAX_ITER)) begin
                state_d = DONE;
                div_d   = 1'b0;
                cnt_d   = ITER_W'(MAX_ITER);
            end else begin
                z_re_d  = zr2 - zi2 + c_re_q;
                z_im_d  = (zri <<< 1) + c_im_q;
                n_d     = n_q + ITER_W'(1);
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            c_re_q  <= '0;
            c_im_q  <= '0;
            z_re_q  <= '0;
            z_im_q  <= '0;
            n_q     <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            c_re_q  <= c_re_d;
            c_im_q  <= c_im_d;
            z_re_q  <= z_re_d;
            z_im_q  <= z_im_d;
            n_q     <= n_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign diverged   = div_q;
    assign iter_count = cnt_q;
endmodule
